// File: rtl/op_sequencer.sv
// Operation sequencer: accepts op words, then drives tiled stream counters, serial bursts, drain and done.
// Optional busy-cycle counter enabled by defining OPSEQ_PERF_EN.
module op_sequencer #(
  parameter int TILE      = 8,
  parameter int K_W       = 6,
  parameter int T_W       = 3,
  parameter int DRAIN_LAT = 16,
  parameter int CNT_W     = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           enable,
  input  logic           op_valid,
  output logic           op_ready,
  input  logic [31:0]    op_word,
  input  logic [K_W-1:0] dim_k,
  input  logic [T_W-1:0] dim_n,
  input  logic [T_W-1:0] dim_m,
  output logic [31:0]    cur_op,
  output logic           stream_en,
  output logic [K_W-1:0] ind_wc,
  output logic [T_W-1:0] ind_wl,
  output logic [T_W-1:0] ind_xl,
  output logic           w_switch,
  output logic           x_switch,
  input  logic           in_valid,
  output logic           ser_we,
  output logic           ser_re,
  output logic           rd_valid,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [31:0]    perf_cycles
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STREAM = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_SER_WR = 3'd3;
  localparam logic [2:0] S_SER_RD = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam int DW = $clog2(DRAIN_LAT + 1);
  localparam int WW = K_W + T_W + 2;

  if (TILE < 1 || DRAIN_LAT < 1) begin : g_bad_param
    $error("op_sequencer: TILE and DRAIN_LAT must be at least 1");
  end

  logic [2:0]       state_q, state_d;
  logic [31:0]      cur_op_q, cur_op_d;
  logic [K_W-1:0]   dk_q, dk_d, wc_q, wc_d;
  logic [T_W-1:0]   dn_q, dn_d, dm_q, dm_d, wl_q, wl_d, xl_q, xl_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] ser_cnt_q, ser_cnt_d;
  logic             err_q, err_d;
  logic             rd_valid_q;
  logic             accept, reject;
  logic [WW-1:0]    w_words;
  logic [CNT_W-1:0] w_last;

  assign op_ready  = (state_q == S_IDLE) && enable;
  assign accept    = op_valid && op_ready;
  assign reject    = (op_word[3:0] > 4'd3) ||
                     ((op_word[3:0] == 4'd1) && (op_word[7:6] == op_word[11:10]));

  assign stream_en = (state_q == S_STREAM);
  assign w_switch  = stream_en && (wc_q == dk_q);
  assign x_switch  = w_switch && (wl_q == dn_q);
  assign ser_we    = (state_q == S_SER_WR) && in_valid && enable;
  assign ser_re    = (state_q == S_SER_RD) && enable;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign rd_valid  = rd_valid_q;
  assign cur_op    = cur_op_q;
  assign ind_wc    = wc_q;
  assign ind_wl    = wl_q;
  assign ind_xl    = xl_q;

  // Serial burst length is one X-line slice: (dim_m+1)*(dim_k+1) words.
  assign w_words = (WW'(dm_q) + WW'(1)) * (WW'(dk_q) + WW'(1));
  assign w_last  = CNT_W'(w_words - WW'(1));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    cur_op_d  = cur_op_q;
    dk_d      = dk_q;
    dn_d      = dn_q;
    dm_d      = dm_q;
    wc_d      = wc_q;
    wl_d      = wl_q;
    xl_d      = xl_q;
    drain_d   = drain_q;
    ser_cnt_d = ser_cnt_q;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (reject) begin
            err_d = 1'b1;
          end else begin
            cur_op_d = op_word;
            dk_d     = dim_k;
            dn_d     = dim_n;
            dm_d     = dim_m;
            case (op_word[3:0])
              4'd0:    state_d = S_DONE;
              4'd1:    state_d = S_STREAM;
              4'd2:    state_d = S_SER_WR;
              default: state_d = S_SER_RD;
            endcase
          end
        end
      end
      S_STREAM: begin
        if (w_switch) begin
          wc_d = '0;
          if (x_switch) begin
            wl_d = '0;
            if (xl_q == dm_q) begin
              xl_d    = '0;
              state_d = S_DRAIN;
            end else begin
              xl_d = xl_q + T_W'(1);
            end
          end else begin
            wl_d = wl_q + T_W'(1);
          end
        end else begin
          wc_d = wc_q + K_W'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == DW'(DRAIN_LAT - 1)) begin
          drain_d = '0;
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      S_SER_WR, S_SER_RD: begin
        // Writes advance only on in_valid; reads stream back-to-back.
        if (in_valid || (state_q == S_SER_RD)) begin
          if (ser_cnt_q == w_last) begin
            ser_cnt_d = '0;
            state_d   = S_DONE;
          end else begin
            ser_cnt_d = ser_cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        cur_op_d = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cur_op_q   <= '0;
      dk_q       <= '0;
      dn_q       <= '0;
      dm_q       <= '0;
      wc_q       <= '0;
      wl_q       <= '0;
      xl_q       <= '0;
      drain_q    <= '0;
      ser_cnt_q  <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else if (enable) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      cur_op_q   <= cur_op_d;
      dk_q       <= dk_d;
      dn_q       <= dn_d;
      dm_q       <= dm_d;
      wc_q       <= wc_d;
      wl_q       <= wl_d;
      xl_q       <= xl_d;
      drain_q    <= drain_d;
      ser_cnt_q  <= ser_cnt_d;
      err_q      <= err_d;
      rd_valid_q <= ser_re;
    end
  end

`ifdef OPSEQ_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_q <= '0;
    end else if (enable && busy && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule
